div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divide unit, one quotient bit per cycle, covering DIV, DIVU, REM and REMU. It sits upstream of the register file. Decode hands it operands and a destination register. It returns the result on a write-back port that the core muxes onto the register file write inputs (write enable, destination index, write data). Results are held until the core grants the shared write port.

## Interface
Parameters:
- none (width fixed at 32; register index fixed at 5 bits)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rd  in  5  destination register index
- rs1val  in  32  dividend
- rs2val  in  32  divisor
- busy  out  1  high in CALC and WB states
- wb_wr  out  1  write-back request; drives the register file write enable when granted
- wb_rd  out  5  destination index, valid while wb_wr
- wb_data  out  32  result, valid while wb_wr
- wb_gnt  in  1  core grants the register file write port this cycle

## Operation
- States:
  - IDLE: busy=0, wb_wr=0.
  - CALC: busy=1, wb_wr=0.
  - WB: busy=1, wb_wr=1.
- In IDLE, start=1 at an edge captures op, rd, rs1val and rs2val into internal registers. Later changes on these inputs are ignored until the next accepted start.
- Special cases are detected at capture and skip CALC, going straight to WB:
  - Divisor 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU result = dividend.
  - Signed overflow (DIV/REM with rs1val=0x80000000 and rs2val=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- Normal case, entry to CALC:
  - For signed ops, take absolute values of both operands.
  - Record the quotient sign as sign(rs1) XOR sign(rs2), and the remainder sign as sign(rs1).
- CALC algorithm: 32 iterations of restoring shift-subtract, using a 33-bit partial remainder and a 32-bit quotient shift register.
- End of CALC:
  - Negate the quotient and/or remainder according to the recorded signs (two's complement, 32-bit wrap).
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - Register the selected value into wb_data, then enter WB.
- In WB:
  - wb_wr, wb_rd and wb_data are held stable until an edge with wb_gnt=1.
  - That edge moves the unit to IDLE, and wb_wr falls.
- rd=0: the computation runs normally, but the unit bypasses WB and returns to IDLE with wb_wr never asserted. Writes to x0 are never emitted.
- start while busy=1 is ignored. This includes the WB cycle in which wb_gnt=1; the core must re-present start after busy falls.
- wb_gnt while not in WB is ignored.

## Timing
- All outputs are registered.
- Reset values: busy=0, wb_wr=0, wb_rd=0, wb_data=0. The state is IDLE and the iteration counter is 0.
- rst asserted at any time, including mid-CALC or in WB, clears immediately without waiting for a clock edge. Any in-flight result is discarded and no write-back is issued.
- Normal latency:
  - The start edge is E0, and busy rises after E0.
  - Iterations occur on edges E1..E32.
  - wb_wr rises after E32, so the first possible grant edge is E33.
- Special-case latency: wb_wr rises after E0, so the earliest grant edge is E1.
- Minimum occupancy is 34 cycles for a normal op and 2 cycles for a special case, assuming immediate grant.
- busy falls after the grant edge. The earliest next accepted start is the following edge.
- The iteration counter is 5 bits, counting 0..31, and is cleared on entry to CALC.

## Test plan
- DIVU 100/7, rd=5, wb_gnt tied high:
  - wb_wr rises after E32 with wb_rd=5 and wb_data=14.
  - Repeating with REMU gives wb_data=2.
- DIV -7/2 gives 0xFFFFFFFD (-3). REM -7/2 gives 0xFFFFFFFF (-1). REM 7/-2 gives 1.
- Special cases:
  - DIV 5/0 gives 0xFFFFFFFF after E0.
  - REMU 0x1234/0 gives 0x1234.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000, and REM on the same operands gives 0; both within 1 cycle.
- Hold wb_gnt low for 5 cycles in WB:
  - wb_wr, wb_rd and wb_data stay stable and busy stays 1.
  - A start pulse issued during WB is ignored.
  - After the grant edge, wb_wr=0 and busy=0.
- Assert rst asynchronously at iteration 10 of CALC:
  - busy, wb_wr, wb_rd and wb_data go to 0 immediately.
  - No wb_wr is issued afterward.
  - A new DIVU 9/3 then returns 3 with normal latency.
- DIVU 100/7 with rd=0: busy is high for 33 cycles, wb_wr never rises, and the unit returns to IDLE.

Source files
------------

// File: rtl/div_unit_if.sv
// Operand request and write-back signals shared between the core and div_unit.
// A request is accepted on an edge where start=1 and busy=0; a result transfers on an edge where wb_wr=1 and wb_gnt=1.
interface div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  rd;
  logic [31:0] rs1val;
  logic [31:0] rs2val;
  logic        busy;
  logic        wb_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_gnt;

  modport master (
    output start, op, rd, rs1val, rs2val, wb_gnt,
    input  busy, wb_wr, wb_rd, wb_data
  );

  modport slave (
    input  start, op, rd, rs1val, rs2val, wb_gnt,
    output busy, wb_wr, wb_rd, wb_data
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm, one quotient bit per cycle.
// The result is held on the write-back port until the core grants the register file write.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic        sel_rem;
  logic        busy_q;
  logic        wb_wr_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  // Capture-time decode of the incoming request
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic        ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] special_res;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.rs1val[31];
  assign b_neg     = is_signed & bus.rs2val[31];
  assign abs_a     = a_neg ? (32'd0 - bus.rs1val) : bus.rs1val;
  assign abs_b     = b_neg ? (32'd0 - bus.rs2val) : bus.rs2val;
  assign div_zero  = (bus.rs2val == 32'd0);
  assign ovf       = is_signed && (bus.rs1val == 32'h8000_0000) && (bus.rs2val == 32'hFFFF_FFFF);

  always_comb begin
    special_res = 32'd0;
    if (div_zero)
      special_res = bus.op[1] ? bus.rs1val : 32'hFFFF_FFFF;
    else
      special_res = bus.op[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [33:0] trial;
  logic [33:0] diff;
  logic        fits;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] result;

  assign trial   = {rem, quo[31]};
  assign diff    = trial - {2'b00, dvs};
  assign fits    = ~diff[33];
  assign rem_nxt = fits ? diff[32:0] : trial[32:0];
  assign quo_nxt = {quo[30:0], fits};
  assign q_fin   = q_neg ? (32'd0 - quo_nxt) : quo_nxt;
  assign r_fin   = r_neg ? (32'd0 - rem_nxt[31:0]) : rem_nxt[31:0];
  assign result  = sel_rem ? r_fin : q_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      rem       <= 33'd0;
      quo       <= 32'd0;
      dvs       <= 32'd0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      sel_rem   <= 1'b0;
      busy_q    <= 1'b0;
      wb_wr_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            wb_rd_q <= bus.rd;
            sel_rem <= bus.op[1];
            cnt     <= 5'd0;
            if (div_zero || ovf) begin
              wb_data_q <= special_res;
              wb_wr_q   <= (bus.rd != 5'd0);
              state     <= WB;
            end else begin
              rem   <= 33'd0;
              quo   <= abs_a;
              dvs   <= abs_b;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            wb_data_q <= result;
            wb_wr_q   <= (wb_rd_q != 5'd0);
            state     <= WB;
          end
        end
        WB: begin
          // With rd=0 nothing is offered, so this cycle only drains
          if (!wb_wr_q || bus.wb_gnt) begin
            wb_wr_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          wb_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wb_wr   = wb_wr_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic model, write-back scoreboard, latency and hold checks.
module tb_div_unit;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  div_unit_if bus ();

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference RV32M semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        ov;
    sa = a;
    sb = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  model = (b == 0) ? 32'hFFFF_FFFF : (ov ? 32'h8000_0000 : 32'(sa / sb));
      OP_DIVU: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  model = (b == 0) ? a : (ov ? 32'd0 : 32'(sa % sb));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    is_special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst && bus.wb_wr) begin
      if (exp_q.size() == 0) begin
        chk("wb_wr_unexpected", 32'd1, 32'd0);
      end else begin
        chk("sb_wb_rd", {27'd0, bus.wb_rd}, {27'd0, exp_q[0][36:32]});
        chk("sb_wb_data", bus.wb_data, exp_q[0][31:0]);
        if (bus.wb_gnt) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rd     = 5'd0;
    bus.rs1val = 32'd0;
    bus.rs2val = 32'd0;
    bus.wb_gnt = 1'b0;
  endtask

  // Issue one op; hold = cycles the grant is withheld once wb_wr is up
  task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic [31:0] lit);
    logic [31:0] m;
    int          n;
    int          lat;
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    m   = model(op, a, b);
    chk("model_pin", m, lit);
    lat = is_special(op, a, b) ? 0 : 32;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.rd = rd; bus.rs1val = a; bus.rs2val = b;
    if (rd != 0) exp_q.push_back({rd, m});
    @(posedge clk); #1;   // E0
    bus.start  = 1'b0;
    bus.op     = 2'($urandom_range(0, 3));
    bus.rd     = 5'($urandom_range(0, 31));
    bus.rs1val = $urandom;
    bus.rs2val = $urandom;
    chk("busy_after_e0", {31'd0, bus.busy}, 32'd1);
    if (rd == 0) begin
      n = 0;
      while (bus.busy && n < 100) begin
        chk("rd0_no_wb_wr", {31'd0, bus.wb_wr}, 32'd0);
        n++;
        @(posedge clk); #1;
      end
      chk("rd0_busy_cycles", n, lat + 1);
      return;
    end
    n = 0;
    while (!bus.wb_wr && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wb_latency", n, lat);
    held_data = bus.wb_data;
    held_rd   = bus.wb_rd;
    for (int i = 0; i < hold; i++) begin
      bus.start = (i == 1);
      bus.op = OP_DIVU; bus.rd = 5'd11; bus.rs1val = 32'd50; bus.rs2val = 32'd5;
      @(posedge clk); #1;
      chk("hold_wb_wr", {31'd0, bus.wb_wr}, 32'd1);
      chk("hold_busy", {31'd0, bus.busy}, 32'd1);
      chk("hold_wb_rd", {27'd0, bus.wb_rd}, {27'd0, held_rd});
      chk("hold_wb_data", bus.wb_data, held_data);
    end
    bus.wb_gnt = 1'b1;
    bus.start  = (hold > 0);   // a start coinciding with the grant must be dropped
    @(posedge clk); #1;
    bus.wb_gnt = 1'b0;
    bus.start  = 1'b0;
    chk("post_gnt_wb_wr", {31'd0, bus.wb_wr}, 32'd0);
    chk("post_gnt_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wb_wr", {31'd0, bus.wb_wr}, 32'd0);
    chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    rst = 1'b0;

    run_op(OP_DIVU, 5'd5, 32'd100, 32'd7, 0, 32'd14);
    run_op(OP_REMU, 5'd5, 32'd100, 32'd7, 0, 32'd2);
    run_op(OP_DIV,  5'd1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD);
    run_op(OP_REM,  5'd2, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF);
    run_op(OP_REM,  5'd3, 32'd7, 32'hFFFF_FFFE, 0, 32'd1);
    run_op(OP_DIV,  5'd4, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
    run_op(OP_REMU, 5'd6, 32'h1234, 32'd0, 0, 32'h1234);
    run_op(OP_DIV,  5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run_op(OP_REM,  5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run_op(OP_DIVU, 5'd12, 32'hFFFF_FFFF, 32'd1, 0, 32'hFFFF_FFFF);
    run_op(OP_DIV,  5'd13, 32'hFFFF_FFFF, 32'h8000_0000, 0, 32'd0);
    run_op(OP_REM,  5'd14, 32'hFFFF_FFFF, 32'h8000_0000, 0, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run_op(OP_DIVU, 5'd10, 32'd1000, 32'd3, 5, 32'd333);
    run_op(OP_DIVU, 5'd0, 32'd100, 32'd7, 0, 32'd14);
    run_op(OP_DIV,  5'd0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rd = 5'd3; bus.rs1val = 32'd100; bus.rs2val = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_wb_wr", {31'd0, bus.wb_wr}, 32'd0);
    chk("arst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    chk("arst_wb_data", bus.wb_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.wb_wr || bus.busy) n++;
    end
    chk("arst_no_wb_after", n, 32'd0);
    run_op(OP_DIVU, 5'd7, 32'd9, 32'd3, 0, 32'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
